fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and next-PC stage that sits directly upstream of the instruction decoder. It owns the PC register, the CMP flag register and the run/halt state machine. Each cycle it drives the instruction-memory address and selects the next PC from the decoder's branch and halt controls: sequential, relative, absolute via a 16-entry target LUT, or hold.

## Interface
- PC_W, 10, program counter / instruction-memory address width
- LUT_DEPTH, 16, absolute-branch target LUT entries (index width 4)
- clk  in  1  system clock, all state rises on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALTED
- abs_branch_en  in  1  decoder: absolute branch instruction
- rel_branch_en  in  1  decoder: relative branch instruction
- cond_sel  in  2  decoder: COND_NONE/COND_LT/COND_GT/COND_EQ
- rel_branch_offset  in  4  decoder: signed two's-complement offset
- abs_branch_LUT_index  in  4  decoder: LUT index
- halt_en  in  1  decoder: HALT instruction
- flag_wen  in  1  ALU executed CMP this cycle
- cmp_lt, cmp_gt, cmp_eq  in  1 each  ALU compare results
- pc  out  PC_W  current instruction address
- fetch_en  out  1  high in RUN; decoder inputs valid only when high
- branch_taken  out  1  combinational: branch resolved taken this cycle
- done  out  1  high while in HALTED

## Operation
- States: IDLE, RUN, HALTED.
  - IDLE: start goes to RUN with pc=0.
  - RUN: halt_en goes to HALTED with pc held. Otherwise pc=next_pc.
  - HALTED: start goes to RUN with pc=0. Flags are cleared.
  - start is ignored in RUN.
- Decoder and ALU inputs are ignored outside RUN.
- Flag register {lt,gt,eq}: loaded from cmp_* when flag_wen && RUN.
- Branch condition uses the registered flags, i.e. the value before any same-cycle update.
- cond_ok: COND_NONE→1, COND_LT→lt, COND_GT→gt, COND_EQ→eq.
- branch_taken = fetch_en & (abs_branch_en | rel_branch_en) & cond_ok.
- next_pc priority:
  1. halt_en: hold.
  2. abs taken: LUT[abs_branch_LUT_index].
  3. rel taken: pc + sign_extend(offset).
  4. Otherwise: pc + 1.
- Arithmetic is modulo 2^PC_W. Wrap-around is legal: pc=0 with offset -1 gives 2^PC_W-1, and pc=max with +1 gives 0.
- Relative offset 0 is a taken self-loop and is not an error.
- abs_branch_en and rel_branch_en both asserted is illegal. If it happens, absolute wins.

## Timing
- Reset values: pc=0, state IDLE, flags 000, fetch_en=0, done=0, branch_taken=0.
- Reset may assert mid-RUN. It takes effect immediately and asynchronously.
- Latency:
  - The PC update is visible one cycle after the instruction is presented.
  - fetch_en rises the cycle after the start pulse.
  - done rises the cycle after halt_en.
- Instruction memory is combinational on pc, one instruction per RUN cycle, no stall.

## Configuration
- FETCH_CYCLE_COUNT_EN defined:
  - Adds output cycle_count (16 bits), counting RUN cycles.
  - Saturates at 16'hFFFF.
  - Clears to 0 on start and on reset.
  - Holds in HALTED, for performance measurement.
- Undefined: no port, no counter logic.

## Structure
- Shared package, next to the existing opcode/condition definitions:
  - cond_sel encodings (COND_*).
  - fetch_state_t enum.
  - ABS_BRANCH_TARGETS constant array (LUT_DEPTH × PC_W).
- Sub-module branch_target_lut: combinational index→target lookup from the package constant.

## Test plan
- Reset then start: pc 0,1,2,3 on successive cycles, fetch_en=1 from the cycle after start.
- Flags lt=1 via CMP, then at pc=5 rel branch COND_LT with offset 4'b1110 → pc=3. Same with eq flag only → pc=6, branch_taken=0.
- pc=0, COND_NONE rel offset 4'b1111 → pc=2^PC_W-1. Then pc=2^PC_W-1, no branch → pc=0.
- Abs branch index 7, COND_EQ, eq=1 → pc=ABS_BRANCH_TARGETS[7]. Same-cycle flag_wen with eq=0 does not alter the decision.
- HALT at pc=9 → pc stays 9, done=1 next cycle, later branches ignored. Then start → pc=0, done=0, flags 000.
- rst_n low mid-RUN at pc=12 → pc=0, IDLE immediately. With FETCH_CYCLE_COUNT_EN, cycle_count=0 after reset and after restart.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the fetch stage.
// Holds the branch condition encodings, the fetch FSM state type and the
// absolute-branch target table used by branch_target_lut.
package fetch_unit_pkg;

   localparam int PC_W      = 10;
   localparam int LUT_DEPTH = 16;
   localparam int LUT_IDX_W = 4;

   // Branch condition select encodings driven by the decoder.
   localparam logic [1:0] COND_NONE = 2'd0;
   localparam logic [1:0] COND_LT   = 2'd1;
   localparam logic [1:0] COND_GT   = 2'd2;
   localparam logic [1:0] COND_EQ   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Absolute-branch destinations, indexed by the decoder's LUT index.
   localparam logic [PC_W-1:0] ABS_BRANCH_TARGETS [LUT_DEPTH] = '{
      10'h010, 10'h025, 10'h03A, 10'h050,
      10'h009, 10'h0A0, 10'h0C3, 10'h155,
      10'h1FF, 10'h200, 10'h2AA, 10'h300,
      10'h333, 10'h3C0, 10'h3FE, 10'h3FF
   };

endpackage

// File: rtl/branch_target_lut.sv
// branch_target_lut: combinational index-to-target lookup for absolute
// branches, backed by the constant table in fetch_unit_pkg.
module branch_target_lut
   import fetch_unit_pkg::*;
(
   input  logic [LUT_IDX_W-1:0] index,
   output logic [PC_W-1:0]      target
);

   assign target = ABS_BRANCH_TARGETS[index];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, CMP flag register and run/halt FSM.
// Selects the next PC (sequential, relative, absolute via LUT, or hold)
// from the decoder's branch and halt controls.
// Optional feature: define FETCH_CYCLE_COUNT_EN to add a saturating 16-bit
// cycle_count output counting RUN cycles.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abs_branch_en,
   input  logic            rel_branch_en,
   input  logic [1:0]      cond_sel,
   input  logic [3:0]      rel_branch_offset,
   input  logic [3:0]      abs_branch_LUT_index,
   input  logic            halt_en,
   input  logic            flag_wen,
   input  logic            cmp_lt,
   input  logic            cmp_gt,
   input  logic            cmp_eq,
   output logic [PC_W-1:0] pc,
   output logic            fetch_en,
   output logic            branch_taken,
   output logic            done
`ifdef FETCH_CYCLE_COUNT_EN
   ,
   output logic [15:0]     cycle_count
`endif
);

   fetch_state_t    state;
   fetch_state_t    next_state;
   logic [PC_W-1:0] next_pc;
   logic [PC_W-1:0] lut_target;
   logic [PC_W-1:0] rel_target;
   logic            flag_lt;
   logic            flag_gt;
   logic            flag_eq;
   logic            cond_ok;
   logic            run;
   logic            abs_taken;
   logic            rel_taken;
   logic            start_accept;

   branch_target_lut u_lut (
      .index  (abs_branch_LUT_index),
      .target (lut_target)
   );

   assign run          = (state == RUN);
   assign start_accept = start & (state != RUN);
   assign fetch_en     = run;
   assign done         = (state == HALTED);

   // Relative target wraps naturally modulo 2^PC_W after sign extension.
   assign rel_target = pc + {{(PC_W-4){rel_branch_offset[3]}}, rel_branch_offset};

   // Branch condition is judged on the registered flags only, so a CMP in
   // the same cycle cannot influence the branch it sits next to.
   always_comb begin
      cond_ok = 1'b1;
      case (cond_sel)
         COND_LT: cond_ok = flag_lt;
         COND_GT: cond_ok = flag_gt;
         COND_EQ: cond_ok = flag_eq;
         default: cond_ok = 1'b1;
      endcase
   end

   // Absolute wins if the decoder ever asserts both branch enables.
   assign abs_taken    = run & abs_branch_en & cond_ok;
   assign rel_taken    = run & rel_branch_en & ~abs_branch_en & cond_ok;
   assign branch_taken = run & (abs_branch_en | rel_branch_en) & cond_ok;

   // Next-state and next-PC selection; halt holds the PC in place.
   always_comb begin
      next_state = state;
      next_pc    = pc;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               next_pc    = '0;
            end
         end
         RUN: begin
            if (halt_en) begin
               next_state = HALTED;
            end else if (abs_taken) begin
               next_pc = lut_target;
            end else if (rel_taken) begin
               next_pc = rel_target;
            end else begin
               next_pc = pc + PC_W'(1);
            end
         end
         HALTED: begin
            if (start) begin
               next_state = RUN;
               next_pc    = '0;
            end
         end
         default: begin
            next_state = IDLE;
            next_pc    = '0;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
      end else begin
         state <= next_state;
         pc    <= next_pc;
      end
   end

   // Compare flags: cleared on every (re)start, loaded by CMP while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {flag_lt, flag_gt, flag_eq} <= 3'b000;
      end else if (start_accept) begin
         {flag_lt, flag_gt, flag_eq} <= 3'b000;
      end else if (run && flag_wen) begin
         {flag_lt, flag_gt, flag_eq} <= {cmp_lt, cmp_gt, cmp_eq};
      end
   end

`ifdef FETCH_CYCLE_COUNT_EN
   // RUN-cycle counter for performance measurement; saturates, holds when halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= '0;
      end else if (start_accept) begin
         cycle_count <= '0;
      end else if (run && (cycle_count != 16'hFFFF)) begin
         cycle_count <= cycle_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural model
// checked on every falling clock edge plus hand-computed literal checks.
// Optional feature: FETCH_CYCLE_COUNT_EN adds cycle_count checks.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PC_MOD = 1 << PC_W;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abs_branch_en;
   logic            rel_branch_en;
   logic [1:0]      cond_sel;
   logic [3:0]      rel_branch_offset;
   logic [3:0]      abs_branch_LUT_index;
   logic            halt_en;
   logic            flag_wen;
   logic            cmp_lt;
   logic            cmp_gt;
   logic            cmp_eq;
   logic [PC_W-1:0] pc;
   logic            fetch_en;
   logic            branch_taken;
   logic            done;
`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0]     cycle_count;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   // Independent copy of the absolute-branch destinations.
   int exp_lut [16] = '{
      'h010, 'h025, 'h03A, 'h050, 'h009, 'h0A0, 'h0C3, 'h155,
      'h1FF, 'h200, 'h2AA, 'h300, 'h333, 'h3C0, 'h3FE, 'h3FF
   };

   int mdl_pc   = 0;
   int mdl_mode = M_IDLE;
   bit mdl_lt   = 1'b0;
   bit mdl_gt   = 1'b0;
   bit mdl_eq   = 1'b0;
   int mdl_cnt  = 0;

   fetch_unit dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .abs_branch_en        (abs_branch_en),
      .rel_branch_en        (rel_branch_en),
      .cond_sel             (cond_sel),
      .rel_branch_offset    (rel_branch_offset),
      .abs_branch_LUT_index (abs_branch_LUT_index),
      .halt_en              (halt_en),
      .flag_wen             (flag_wen),
      .cmp_lt               (cmp_lt),
      .cmp_gt               (cmp_gt),
      .cmp_eq               (cmp_eq),
      .pc                   (pc),
      .fetch_en             (fetch_en),
      .branch_taken         (branch_taken),
      .done                 (done)
`ifdef FETCH_CYCLE_COUNT_EN
      ,
      .cycle_count          (cycle_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit cond_ok_f(input logic [1:0] c, input bit lt, input bit gt, input bit eq);
      case (c)
         2'd1:    return lt;
         2'd2:    return gt;
         2'd3:    return eq;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int model_next_pc(input int cur, input bit halt, input bit abs_en,
                                        input bit rel_en, input logic [1:0] c,
                                        input logic [3:0] off, input logic [3:0] idx,
                                        input bit lt, input bit gt, input bit eq);
      bit ok   = cond_ok_f(c, lt, gt, eq);
      int soff = (off >= 4'd8) ? int'(off) - 16 : int'(off);
      if (halt) return cur;
      if (abs_en && ok) return exp_lut[idx];
      if (rel_en && ok) return (cur + soff + PC_MOD) % PC_MOD;
      return (cur + 1) % PC_MOD;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model of the fetch stage, advanced on the same edges as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_pc   <= 0;
         mdl_mode <= M_IDLE;
         mdl_lt   <= 1'b0;
         mdl_gt   <= 1'b0;
         mdl_eq   <= 1'b0;
         mdl_cnt  <= 0;
      end else if (mdl_mode == M_RUN) begin
         mdl_pc <= model_next_pc(mdl_pc, halt_en, abs_branch_en, rel_branch_en, cond_sel,
                                 rel_branch_offset, abs_branch_LUT_index,
                                 mdl_lt, mdl_gt, mdl_eq);
         if (halt_en) mdl_mode <= M_HALT;
         if (flag_wen) begin
            mdl_lt <= cmp_lt;
            mdl_gt <= cmp_gt;
            mdl_eq <= cmp_eq;
         end
         if (mdl_cnt < 65535) mdl_cnt <= mdl_cnt + 1;
      end else if (start) begin
         mdl_mode <= M_RUN;
         mdl_pc   <= 0;
         mdl_lt   <= 1'b0;
         mdl_gt   <= 1'b0;
         mdl_eq   <= 1'b0;
         mdl_cnt  <= 0;
      end
   end

   // Compare every DUT output against the model away from the rising edge.
   always @(negedge clk) begin
      check_output("model_pc", int'(pc), mdl_pc);
      check_output("model_fetch_en", int'(fetch_en), int'(mdl_mode == M_RUN));
      check_output("model_done", int'(done), int'(mdl_mode == M_HALT));
      check_output("model_branch_taken", int'(branch_taken),
                   int'((mdl_mode == M_RUN) && (abs_branch_en || rel_branch_en) &&
                        cond_ok_f(cond_sel, mdl_lt, mdl_gt, mdl_eq)));
`ifdef FETCH_CYCLE_COUNT_EN
      check_output("model_cycle_count", int'(cycle_count), mdl_cnt);
`endif
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      abs_branch_en        = 1'b0;
      rel_branch_en        = 1'b0;
      cond_sel             = COND_NONE;
      rel_branch_offset    = 4'd0;
      abs_branch_LUT_index = 4'd0;
      halt_en              = 1'b0;
      flag_wen             = 1'b0;
      cmp_lt               = 1'b0;
      cmp_gt               = 1'b0;
      cmp_eq               = 1'b0;
   endtask

   task automatic apply_stimulus(input bit abs_en, input bit rel_en, input logic [1:0] c,
                                 input logic [3:0] off, input logic [3:0] idx, input bit halt,
                                 input bit fw, input bit lt, input bit gt, input bit eq);
      abs_branch_en        = abs_en;
      rel_branch_en        = rel_en;
      cond_sel             = c;
      rel_branch_offset    = off;
      abs_branch_LUT_index = idx;
      halt_en              = halt;
      flag_wen             = fw;
      cmp_lt               = lt;
      cmp_gt               = gt;
      cmp_eq               = eq;
   endtask

   // Watchdog so the bench always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence with hand-computed expectations.
   initial begin
      clear_inputs();
      repeat (3) cycle();
      check_output("reset_pc", int'(pc), 0);
      check_output("reset_fetch_en", int'(fetch_en), 0);
      check_output("reset_done", int'(done), 0);
      check_output("reset_branch_taken", int'(branch_taken), 0);
      rst_n = 1'b1;
      cycle();
      check_output("idle_fetch_en", int'(fetch_en), 0);

      start = 1'b1;
      cycle();
      start = 1'b0;
      check_output("start_fetch_en", int'(fetch_en), 1);
      check_output("start_pc", int'(pc), 0);
      cycle(); check_output("seq_pc1", int'(pc), 1);
      cycle(); check_output("seq_pc2", int'(pc), 2);
      cycle(); check_output("seq_pc3", int'(pc), 3);

      apply_stimulus(0, 0, COND_NONE, 4'd0, 4'd0, 0, 1, 1, 0, 0);
      cycle();
      clear_inputs();
      cycle();
      check_output("pc5_before_lt", int'(pc), 5);
      apply_stimulus(0, 1, COND_LT, 4'b1110, 4'd0, 0, 0, 0, 0, 0);
      #1 check_output("lt_branch_taken", int'(branch_taken), 1);
      cycle();
      check_output("lt_branch_pc", int'(pc), 3);

      apply_stimulus(0, 0, COND_NONE, 4'd0, 4'd0, 0, 1, 0, 0, 1);
      cycle();
      clear_inputs();
      cycle();
      apply_stimulus(0, 1, COND_LT, 4'b1110, 4'd0, 0, 0, 0, 0, 0);
      #1 check_output("lt_not_taken", int'(branch_taken), 0);
      cycle();
      check_output("lt_fallthrough_pc", int'(pc), 6);

      apply_stimulus(0, 1, COND_NONE, 4'b1010, 4'd0, 0, 0, 0, 0, 0);
      cycle();
      check_output("rel_back_to_0", int'(pc), 0);
      apply_stimulus(0, 1, COND_NONE, 4'b1111, 4'd0, 0, 0, 0, 0, 0);
      cycle();
      check_output("wrap_down_pc", int'(pc), 1023);
      clear_inputs();
      cycle();
      check_output("wrap_up_pc", int'(pc), 0);
      apply_stimulus(0, 1, COND_NONE, 4'b0000, 4'd0, 0, 0, 0, 0, 0);
      #1 check_output("self_loop_taken", int'(branch_taken), 1);
      cycle();
      check_output("self_loop_pc", int'(pc), 0);

      apply_stimulus(0, 0, COND_NONE, 4'd0, 4'd0, 0, 1, 0, 0, 1);
      cycle();
      apply_stimulus(1, 0, COND_EQ, 4'd0, 4'd7, 0, 1, 1, 0, 0);
      #1 check_output("abs_eq_taken", int'(branch_taken), 1);
      cycle();
      check_output("abs_target7", int'(pc), 'h155);
      apply_stimulus(1, 0, COND_EQ, 4'd0, 4'd7, 0, 0, 0, 0, 0);
      #1 check_output("abs_eq_not_taken", int'(branch_taken), 0);
      cycle();
      check_output("abs_fallthrough", int'(pc), 'h156);
      apply_stimulus(1, 1, COND_LT, 4'b0001, 4'd3, 0, 0, 0, 0, 0);
      cycle();
      check_output("abs_wins_over_rel", int'(pc), 'h050);

      clear_inputs();
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_output("start_ignored_in_run", int'(pc), 'h051);
      apply_stimulus(1, 0, COND_NONE, 4'd0, 4'd4, 0, 0, 0, 0, 0);
      cycle();
      check_output("abs_to_pc9", int'(pc), 9);

      apply_stimulus(0, 0, COND_NONE, 4'd0, 4'd0, 1, 0, 0, 0, 0);
      cycle();
      check_output("halt_pc_hold", int'(pc), 9);
      check_output("halt_done", int'(done), 1);
      check_output("halt_fetch_en", int'(fetch_en), 0);
      apply_stimulus(1, 1, COND_NONE, 4'b0011, 4'd7, 0, 1, 1, 1, 1);
      #1 check_output("halted_no_branch", int'(branch_taken), 0);
      cycle();
      cycle();
      check_output("halted_pc_hold", int'(pc), 9);

      clear_inputs();
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_output("restart_pc", int'(pc), 0);
      check_output("restart_done", int'(done), 0);
      apply_stimulus(0, 1, COND_LT, 4'b0101, 4'd0, 0, 0, 0, 0, 0);
      #1 check_output("flags_cleared_lt", int'(branch_taken), 0);
      cycle();
      apply_stimulus(0, 1, COND_GT, 4'b0101, 4'd0, 0, 0, 0, 0, 0);
      cycle();
      apply_stimulus(0, 1, COND_EQ, 4'b0101, 4'd0, 0, 0, 0, 0, 0);
      cycle();
      check_output("flags_cleared_pc", int'(pc), 3);
      clear_inputs();

      for (int i = 0; i < 40; i++) begin
         if (pc == 10'd12) break;
         cycle();
      end
      check_output("reach_pc12", int'(pc), 12);
      #3 rst_n = 1'b0;
      #1;
      check_output("async_reset_pc", int'(pc), 0);
      check_output("async_reset_fetch_en", int'(fetch_en), 0);
`ifdef FETCH_CYCLE_COUNT_EN
      check_output("async_reset_count", int'(cycle_count), 0);
`endif
      cycle();
      rst_n = 1'b1;
      cycle();
      check_output("post_reset_idle", int'(fetch_en), 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_output("restart2_fetch_en", int'(fetch_en), 1);
`ifdef FETCH_CYCLE_COUNT_EN
      check_output("restart_count", int'(cycle_count), 0);
      repeat (5) cycle();
      check_output("count_after_5", int'(cycle_count), 5);
`else
      repeat (5) cycle();
      check_output("pc_after_5", int'(pc), 5);
`endif

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
